ps2_scan_decoder: RTL and testbench

- Parametrised PS/2 set-2 scancode decoder between the ps2_if byte FIFO and game logic (TETRIS_GAME and later clients).
- Polls the ps2_if FIFO at a programmable rate and decodes E0, F0 and E1 (Pause) prefix sequences into tagged make/break events.
- Filters controller responses, fake-shift codes and optional typematic repeats.
- Buffers events in an internal FWFT FIFO with a valid/ready handshake, so no key is lost while the consumer is busy.

---
 rtl/ps2_scan_decoder.sv | 185 ++++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scancode decoder: polls the ps2_if byte FIFO and turns E0/F0/E1 prefix sequences into make/break/pause events.
// Events reach ev_valid 2 cycles after byte capture; a busy consumer backs up into an EVT_DEPTH FIFO, and overflow flags any drop.
module ps2_scan_decoder #(
  parameter int POLL_PERIOD   = 64,
  parameter int TIMEOUT_CYC   = 2_500_000,
  parameter int EVT_DEPTH     = 8,
  parameter int FILTER_REPEAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  output logic                       fifo_rd,
  input  logic                       fifo_empty,
  input  logic [7:0]                 fifo_data,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [7:0]                 ev_code,
  output logic                       ev_ext,
  output logic                       ev_break,
  output logic                       ev_pause,
  output logic [$clog2(EVT_DEPTH):0] ev_count,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int PW = $clog2(POLL_PERIOD);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(EVT_DEPTH);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]   DEPTH     = (AW+1)'(EVT_DEPTH);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] EXT     = 3'd1;
  localparam logic [2:0] BRK     = 3'd2;
  localparam logic [2:0] EXT_BRK = 3'd3;
  localparam logic [2:0] PAUSE   = 3'd4;

  logic [PW-1:0] poll_cnt;
  logic          cap;
  logic          byte_vld;
  logic [7:0]    byte_r;

  assign cap = en && (poll_cnt == POLL_LAST) && !fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      poll_cnt <= '0;
      fifo_rd  <= 1'b0;
      byte_vld <= 1'b0;
      byte_r   <= '0;
    end else begin
      if (!en || poll_cnt == POLL_LAST) poll_cnt <= '0;
      else                              poll_cnt <= poll_cnt + 1'b1;
      fifo_rd  <= cap;
      byte_vld <= cap;
      if (cap) byte_r <= fifo_data;
    end
  end

  logic [2:0]    state, nxt_state;
  logic [2:0]    pcnt, nxt_pcnt;
  logic [TW-1:0] tcnt;
  logic          dec_vld, dec_ext, dec_brk, dec_pause;
  logic [7:0]    dec_code;
  logic [511:0]  held;
  logic [8:0]    key_idx;
  logic          keep;

  always_comb begin
    nxt_state = state;
    nxt_pcnt  = pcnt;
    dec_vld   = 1'b0;
    dec_code  = byte_r;
    dec_ext   = 1'b0;
    dec_brk   = 1'b0;
    dec_pause = 1'b0;
    case (state)
      IDLE: begin
        case (byte_r)
          8'hE0: nxt_state = EXT;
          8'hF0: nxt_state = BRK;
          8'hE1: begin nxt_state = PAUSE; nxt_pcnt = 3'd7; end
          8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: ;
          default: dec_vld = 1'b1;
        endcase
      end
      EXT: begin
        case (byte_r)
          8'hF0: nxt_state = EXT_BRK;
          8'hE0: nxt_state = EXT;
          8'h12, 8'h59: nxt_state = IDLE;
          default: begin dec_vld = 1'b1; dec_ext = 1'b1; nxt_state = IDLE; end
        endcase
      end
      BRK: begin
        dec_vld   = 1'b1;
        dec_brk   = 1'b1;
        nxt_state = IDLE;
      end
      EXT_BRK: begin
        dec_vld   = (byte_r != 8'h12) && (byte_r != 8'h59);
        dec_ext   = 1'b1;
        dec_brk   = 1'b1;
        nxt_state = IDLE;
      end
      PAUSE: begin
        nxt_pcnt = pcnt - 3'd1;
        if (pcnt == 3'd1) begin
          dec_vld   = 1'b1;
          dec_pause = 1'b1;
          dec_code  = 8'h77;
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign key_idx = {dec_ext, dec_code};
  // Breaks and pause always pass; only a repeated make of a held key is filtered.
  assign keep = dec_vld && (dec_brk || dec_pause || (FILTER_REPEAT == 0) || !held[key_idx]);

  logic        evt_vld;
  logic [10:0] evt_dat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pcnt    <= '0;
      tcnt    <= '0;
      held    <= '0;
      evt_vld <= 1'b0;
      evt_dat <= '0;
    end else begin
      evt_vld <= byte_vld && keep;
      if (byte_vld) begin
        state   <= nxt_state;
        pcnt    <= nxt_pcnt;
        tcnt    <= '0;
        evt_dat <= {dec_code, dec_ext, dec_brk, dec_pause};
        if (dec_vld && !dec_pause) held[key_idx] <= !dec_brk;
      end else if (state != IDLE && en) begin
        // A stalled prefix sequence is abandoned silently.
        if (tcnt == TO_LAST) begin
          state <= IDLE;
          tcnt  <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

  logic [10:0]   mem [EVT_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, push;

  assign ev_valid = (ev_count != '0);
  assign full     = (ev_count == DEPTH);
  assign pop      = ev_valid && ev_ready;
  assign push     = evt_vld && (!full || pop);
  assign {ev_code, ev_ext, ev_break, ev_pause} = ev_valid ? mem[rd_ptr] : 11'd0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= evt_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      ev_count <= ev_count + 1'b1;
      else if (pop && !push) ev_count <= ev_count - 1'b1;
      if (evt_vld && full && !pop) overflow <= 1'b1;
      else if (ovf_clr)            overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed and randomized checks of ps2_scan_decoder against a key-level reference model.
module tb_ps2_scan_decoder;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       pause;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       fifo_rd;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext, ev_break, ev_pause;
  logic [3:0] ev_count;
  logic       overflow;
  logic       ovf_clr;

  ps2_scan_decoder #(
    .POLL_PERIOD(4), .TIMEOUT_CYC(100), .EVT_DEPTH(8), .FILTER_REPEAT(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .fifo_rd(fifo_rd), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break), .ev_pause(ev_pause),
    .ev_count(ev_count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] ps2_q[$];
  ev_t        got[$];
  ev_t        exp_q[$];
  logic [511:0] held_m;
  logic       rand_ready = 1'b0;
  logic [7:0] pool [6] = '{8'h1C, 8'h1D, 8'h24, 8'h75, 8'h6B, 8'h74};
  logic [7:0] ovf_codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Handshake is recorded before the edge it applies to; the ps2_if model reacts at the negedge.
  task automatic tick();
    if (ev_valid && ev_ready) got.push_back({ev_code, ev_ext, ev_break, ev_pause});
    @(negedge clk);
    if (fifo_rd && ps2_q.size() > 0) void'(ps2_q.pop_front());
    if (rand_ready) ev_ready = ($urandom_range(0, 3) != 0);
    fifo_empty = (ps2_q.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : ps2_q[0];
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ps2_q.delete(); got.delete(); exp_q.delete();
    held_m = '0;
    ev_ready = 1'b0; rand_ready = 1'b0; ovf_clr = 1'b0; en = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk, input logic pause);
    exp_q.push_back({code, ext, brk, pause});
  endtask

  // Key-level model: a make of a held key is swallowed, a break always reports.
  task automatic add_key(input logic [7:0] code, input logic ext, input logic brk);
    logic [8:0] idx;
    idx = {ext, code};
    if (ext) ps2_q.push_back(8'hE0);
    if (brk) ps2_q.push_back(8'hF0);
    ps2_q.push_back(code);
    if (brk) begin
      expect_ev(code, ext, 1'b1, 1'b0);
      held_m[idx] = 1'b0;
    end else if (!held_m[idx]) begin
      expect_ev(code, ext, 1'b0, 1'b0);
      held_m[idx] = 1'b1;
    end
  endtask

  task automatic drain(input string tag);
    int idle;
    int budget;
    idle = 0;
    budget = 6000;
    if (!rand_ready) ev_ready = 1'b1;
    while ((ps2_q.size() != 0 || idle < 12 || ev_valid) && budget > 0) begin
      tick();
      budget--;
      if (ps2_q.size() == 0) idle++; else idle = 0;
    end
    rand_ready = 1'b0;
    ev_ready = 1'b0;
    chk({tag, "_budget"}, 32'(budget > 0), 32'd1);
    chk({tag, "_nevents"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_ev%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    rst = 1'b0; en = 1'b1; ev_ready = 1'b0; ovf_clr = 1'b0;
    fifo_empty = 1'b1; fifo_data = 8'h00; held_m = '0;

    tick();
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_fields", {ev_code, ev_ext, ev_break, ev_pause}, 0);
    chk("rst_ev_count", ev_count, 0);
    chk("rst_overflow", overflow, 0);
    do_reset();

    // Single make: read strobe width and capture-to-valid latency.
    ps2_q.push_back(8'h1C);
    cyc = 0;
    while (!fifo_rd && cyc < 50) begin tick(); cyc++; end
    chk("t1_rd_seen", fifo_rd, 1);
    chk("t1_valid_c0", ev_valid, 0);
    tick();
    chk("t1_rd_one_cycle", fifo_rd, 0);
    chk("t1_valid_c1", ev_valid, 0);
    tick();
    chk("t1_valid_c2", ev_valid, 1);
    chk("t1_event", {ev_code, ev_ext, ev_break, ev_pause}, {8'h1C, 3'b000});
    chk("t1_count", ev_count, 1);
    expect_ev(8'h1C, 0, 0, 0);
    drain("t1");

    // en low blocks polling; extended break and fake-shift filtering.
    do_reset();
    en = 1'b0;
    ps2_q.push_back(8'hE0); ps2_q.push_back(8'hF0); ps2_q.push_back(8'h75);
    for (int i = 0; i < 20; i++) tick();
    chk("t2_en0_noread", ps2_q.size(), 3);
    en = 1'b1;
    expect_ev(8'h75, 1, 1, 0);
    ps2_q.push_back(8'hE0); ps2_q.push_back(8'h12); ps2_q.push_back(8'hE0); ps2_q.push_back(8'h7C);
    expect_ev(8'h7C, 1, 0, 0);
    ps2_q.push_back(8'h1C);
    expect_ev(8'h1C, 0, 0, 0);
    drain("t2");

    // Typematic repeat filter.
    do_reset();
    add_key(8'h1C, 0, 0); add_key(8'h1C, 0, 0); add_key(8'h1C, 0, 0);
    add_key(8'h1C, 0, 1); add_key(8'h1C, 0, 0); add_key(8'h1C, 0, 0);
    drain("t3");

    // Pause sequence, then a prefix abandoned by timeout.
    do_reset();
    foreach (pause_seq[i]) ps2_q.push_back(pause_seq[i]);
    expect_ev(8'h77, 0, 0, 1);
    drain("t4a");
    ps2_q.push_back(8'hE0);
    ev_ready = 1'b1;
    for (int i = 0; i < 150; i++) tick();
    ps2_q.push_back(8'h1C);
    expect_ev(8'h1C, 0, 0, 0);
    drain("t4b");

    // Overflow with a stalled consumer.
    do_reset();
    foreach (ovf_codes[i]) ps2_q.push_back(ovf_codes[i]);
    cyc = 0;
    while (ps2_q.size() != 0 && cyc < 200) begin tick(); cyc++; end
    for (int i = 0; i < 12; i++) tick();
    chk("t5_count_full", ev_count, 8);
    chk("t5_overflow", overflow, 1);
    chk("t5_head", ev_code, 8'h15);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0; tick();
    chk("t5_ovf_cleared", overflow, 0);
    for (int i = 0; i < 8; i++) expect_ev(ovf_codes[i], 0, 0, 0);
    drain("t5");
    chk("t5_count_empty", ev_count, 0);

    // Asynchronous reset in the middle of an E0 F0 prefix.
    do_reset();
    ps2_q.push_back(8'h1C); ps2_q.push_back(8'hE0); ps2_q.push_back(8'hF0);
    cyc = 0;
    while (ps2_q.size() != 0 && cyc < 100) begin tick(); cyc++; end
    tick(); tick();
    chk("t6_pre_valid", ev_valid, 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", ev_valid, 0);
    chk("t6_rst_fields", {fifo_rd, ev_code, ev_ext, ev_break, ev_pause, overflow}, 0);
    chk("t6_rst_count", ev_count, 0);
    tick(); tick();
    rst = 1'b1;
    got.delete(); held_m = '0;
    tick();
    ps2_q.push_back(8'h75);
    expect_ev(8'h75, 0, 0, 0);
    drain("t6");

    // Random key traffic against the key-level model, with a jittery consumer.
    do_reset();
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0: ps2_q.push_back(8'hFA);
        1: begin ps2_q.push_back(8'hE0); ps2_q.push_back(8'h12); end
        2: begin
          foreach (pause_seq[i]) ps2_q.push_back(pause_seq[i]);
          expect_ev(8'h77, 0, 0, 1);
        end
        default: add_key(pool[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                         $urandom_range(0, 2) == 0);
      endcase
    end
    drain("rand");
    chk("rand_no_overflow", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
